// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / exception controller:
// FSM encoding, the "operand unused" T_use value and the exception code width.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_EXC     = 2'd2
  } state_t;

  localparam logic [1:0]  TUSE_NONE  = 2'd3;
  localparam int unsigned EXC_CODE_W = 5;

  // One source operand against the E and M producers; T_use of 3 never stalls.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] t_use,
    input logic [4:0] wr_e,
    input logic [4:0] t_new_e,
    input logic [4:0] wr_m,
    input logic [4:0] t_new_m
  );
    logic hit_e, hit_m;
    hit_e = (src == wr_e) && (t_new_e > {3'b000, t_use});
    hit_m = (src == wr_m) && (t_new_m > {3'b000, t_use});
    return (src != 5'd0) && (t_use != TUSE_NONE) && (hit_e || hit_m);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// MDU busy countdown: loads the op latency, then counts down to zero and holds.
module md_busy_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard, MDU interlock and exception/eret redirect control.
// Build option: define PIPE_HAZARD_CTRL_MDU_EN to include MDU busy tracking.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4:0]              rs_D,
  input  logic [4:0]              rt_D,
  input  logic [1:0]              T_use_rs_D,
  input  logic [1:0]              T_use_rt_D,
  input  logic [4:0]              WriteRegNum_E,
  input  logic [4:0]              WriteRegNum_M,
  input  logic [4:0]              T_new_E,
  input  logic [4:0]              T_new_M,
  input  logic                    md_start_D,
  input  logic                    md_div_D,
  input  logic                    md_use_D,
  input  logic [EXC_CODE_W+1:2]   ExcCode_M,
  input  logic                    int_req,
  input  logic                    eret_M,
  output logic                    en_pc,
  output logic                    en_FD,
  output logic                    flush_DE,
  output logic                    flush_EM,
  output logic                    flush_MW,
  output logic                    pc_sel_exc,
  output logic                    pc_sel_epc,
  output logic                    epc_we,
  output logic                    md_busy,
  output logic [1:0]              state
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             exc_m;
  logic             stall_hz;
  logic             stall_md;
  logic             stall;
  logic             start_ok;

  assign exc_m    = (ExcCode_M != '0) | int_req;
  assign stall_hz = src_hazard(rs_D, T_use_rs_D, WriteRegNum_E, T_new_E, WriteRegNum_M, T_new_M)
                  | src_hazard(rt_D, T_use_rt_D, WriteRegNum_E, T_new_E, WriteRegNum_M, T_new_M);
  assign stall    = stall_hz | stall_md;

`ifdef PIPE_HAZARD_CTRL_MDU_EN
  logic [CNT_W-1:0] cnt_init;

  assign cnt_init = md_div_D ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  assign stall_md = (md_start_D | md_use_D) & busy;
  // An eret flushes the D-stage instruction, so it must not launch the MDU.
  assign start_ok = md_start_D & (state_q == ST_RUN) & ~stall & ~exc_m & ~eret_M;

  md_busy_counter #(
    .CNT_W(CNT_W)
  ) u_md_busy_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (start_ok),
    .load_val(cnt_init),
    .count   (cnt),
    .busy    (busy)
  );
`else
  logic unused_md;

  assign unused_md = md_start_D ^ md_div_D ^ md_use_D;
  assign cnt       = '0;
  assign busy      = 1'b0;
  assign stall_md  = 1'b0;
  assign start_ok  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (exc_m)         state_q <= ST_EXC;
          else if (start_ok) state_q <= ST_MD_BUSY;
        end
        ST_MD_BUSY: begin
          if (exc_m)                   state_q <= ST_EXC;
          else if (cnt <= CNT_W'(1))   state_q <= ST_RUN;
        end
        ST_EXC: begin
          // The counter keeps running through EXC; resume MD_BUSY only if it
          // will still be nonzero after this edge.
          if (exc_m)                   state_q <= ST_EXC;
          else if (cnt > CNT_W'(1))    state_q <= ST_MD_BUSY;
          else                         state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    en_pc      = 1'b1;
    en_FD      = 1'b1;
    flush_DE   = 1'b0;
    flush_EM   = 1'b0;
    flush_MW   = 1'b0;
    pc_sel_exc = 1'b0;
    pc_sel_epc = 1'b0;
    epc_we     = 1'b0;
    if (!reset) begin
      en_pc = 1'b1;
    end else if (exc_m) begin
      pc_sel_exc = 1'b1;
      epc_we     = 1'b1;
      flush_DE   = 1'b1;
      flush_EM   = 1'b1;
      flush_MW   = 1'b1;
    end else if (state_q == ST_EXC) begin
      flush_DE = 1'b1;
      flush_EM = 1'b1;
      flush_MW = 1'b1;
    end else if (eret_M) begin
      pc_sel_epc = 1'b1;
      flush_DE   = 1'b1;
      flush_EM   = 1'b1;
    end else if (stall) begin
      en_pc    = 1'b0;
      en_FD    = 1'b0;
      flush_DE = 1'b1;
    end
  end

  assign md_busy = busy;
  assign state   = state_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, MDU busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, MDU busy cycles for div/divu.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports rs_D, rt_D  in  5  source register numbers of the D-stage instruction.
REQ-006 SHALL have ports T_use_rs_D, T_use_rt_D  in  2  cycles until D instruction needs rs/rt; 3 means unused.
REQ-007 SHALL have ports WriteRegNum_E, WriteRegNum_M  in  5  destination registers in E and M.
REQ-008 SHALL have ports T_new_E, T_new_M  in  5  cycles until E/M result is available.
REQ-009 SHALL have ports md_start_D  in  1  D holds mult/div; md_div_D  in  1  that op is a divide; md_use_D  in  1  D reads or writes HI/LO.
REQ-010 SHALL have ports ExcCode_M  in  5 (bits [6:2])  M-stage exception code, 0 = none; int_req  in  1  external interrupt; eret_M  in  1  eret in M.
REQ-011 SHALL have outputs en_pc, en_FD  out  1  PC and F/D register enables.
REQ-012 SHALL have outputs flush_DE, flush_EM, flush_MW  out  1  synchronous clear requests for the D/E, E/M and M/W registers.
REQ-013 SHALL have outputs pc_sel_exc, pc_sel_epc, epc_we  out  1  PC redirect to handler, PC redirect to EPC, EPC/Cause capture strobe.
REQ-014 SHALL have outputs md_busy  out  1  and state  out  2  for debug.

Function
REQ-015 SHALL raise stall_hz when a nonzero rs_D/rt_D matches WriteRegNum_E with T_new_E > T_use, or matches WriteRegNum_M with T_new_M > T_use.
REQ-016 SHALL raise stall_md when (md_start_D or md_use_D) and md_busy.
REQ-017 On stall (stall_hz or stall_md) and no exception: en_pc=0, en_FD=0, flush_DE=1 (bubble), all other strobes 0, in the same cycle.
REQ-018 SHALL implement states RUN(0), MD_BUSY(1), EXC(2); encoding 3 unreachable and recovers to RUN.
REQ-019 RUN -> MD_BUSY when md_start_D=1, no stall, no exception; counter loads DIV_CYCLES if md_div_D else MULT_CYCLES.
REQ-020 In MD_BUSY the counter decrements by 1 per cycle; md_busy=1 while counter>0; transition to RUN on the edge where the counter reaches 0.
REQ-021 exc_M = (ExcCode_M != 0) | int_req; it has priority over every stall and over eret_M.
REQ-022 In a cycle with exc_M: pc_sel_exc=1, epc_we=1, en_pc=1, en_FD=1 and flush_DE=flush_EM=flush_MW=1; next state EXC.
REQ-023 EXC lasts exactly one cycle with all flushes 1 and pc_sel/epc_we 0, then goes to MD_BUSY if counter>0, else RUN.
REQ-024 The MDU counter SHALL keep decrementing through EXC; an exception does not abort an in-flight mult/div.
REQ-025 eret_M without exc_M: pc_sel_epc=1 and flush_DE=flush_EM=1 for one cycle; no state change.
REQ-026 A second exc_M during EXC SHALL be honoured with REQ-022 behaviour (EXC re-entered).
REQ-027 Counter width SHALL be clog2(max(MULT_CYCLES,DIV_CYCLES)+1) bits; no wrap below 0.

Reset
REQ-028 With reset=0 at a clock edge: state=RUN, counter=0, md_busy=0.
REQ-029 Outputs during and after reset until the first input event: en_pc=en_FD=1, all flushes, pc_sel_exc, pc_sel_epc and epc_we at 0.
REQ-030 Reset mid-MD_BUSY or mid-EXC SHALL abandon the operation with no residual stall.

Configuration
REQ-031 With macro PIPE_HAZARD_CTRL_MDU_EN defined, MDU tracking (REQ-016, REQ-019, REQ-020, REQ-024) SHALL be built.
REQ-032 Without it, md_busy=0 constantly, MD_BUSY is unreachable and md_* inputs are ignored.

Structure
REQ-033 The shared package SHALL hold the state encoding, the T_use "unused" value 3 and the ExcCode width.
REQ-034 The MDU countdown SHALL be one sub-module, md_busy_counter.

Verification
REQ-035 rs_D=5, WriteRegNum_E=5, T_new_E=2, T_use_rs_D=0 -> en_pc=0, en_FD=0, flush_DE=1 for that cycle; rs_D=0 with the same values -> no stall.
REQ-036 md_start_D=1, md_div_D=1 -> md_busy=1 for 10 cycles; md_use_D=1 at cycle 4 -> stall through cycle 10, released at cycle 11.
REQ-037 ExcCode_M=5'd4 together with stall_hz=1 -> pc_sel_exc=1, epc_we=1, all flushes 1, no stall; the next cycle state=EXC; the cycle after, state=RUN.
REQ-038 mult is started, then int_req is asserted at its 2nd busy cycle -> EXC, then MD_BUSY resumes with the counter at 2, and md_busy drops on schedule.
REQ-039 eret_M=1 -> pc_sel_epc=1, flush_DE=flush_EM=1 for one cycle; eret_M=1 together with int_req=1 -> exception path only.
REQ-040 reset=0 asserted during MD_BUSY -> the next cycle shows state=RUN, md_busy=0 and en_pc=1.
